// File: rtl/cnt_shift_pkg.sv
// Shared widths and load constants for the cnt_shift serial-receive datapath.
package cnt_shift_pkg;

   localparam int unsigned SH_W  = 8;
   localparam int unsigned CNT_W = 3;

   localparam logic [SH_W-1:0]  SH_INIT  = 8'h00;
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(0);

   // Terminal count: all ones
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

endpackage : cnt_shift_pkg

// File: rtl/cnt_shift_counter.sv
// Loadable up-counter with a terminal-count flag that marks frame boundaries.
// Ports:
//   clk      rising-edge clock
//   rst_cnt  asynchronous active-high reset, clears cnt (and registered co)
//   en_cnt   count enable
//   ld       synchronous load of CNT_INIT, overrides en_cnt
//   co       terminal-count flag
//   cnt      current count
// Build option CNT_SHIFT_CO_REG_EN: when defined, co is registered and pulses
// on the edge after the terminal-count cycle; otherwise co is combinational.
module cnt_shift_counter
   import cnt_shift_pkg::*;
(
   input  logic             clk,
   input  logic             rst_cnt,
   input  logic             en_cnt,
   input  logic             ld,
   output logic             co,
   output logic [CNT_W-1:0] cnt
);

   logic tc_c;

   // Count register: reset > load > increment > hold; wraps naturally
   always_ff @(posedge clk or posedge rst_cnt) begin
      if (rst_cnt) begin
         cnt <= CNT_W'(0);
      end else if (ld) begin
         cnt <= CNT_INIT;
      end else if (en_cnt) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   // Terminal count only counts when the counter is actually enabled
   assign tc_c = en_cnt & (cnt == CNT_MAX);

`ifdef CNT_SHIFT_CO_REG_EN
   logic co_q;

   // One-cycle pulse following the terminal-count cycle
   always_ff @(posedge clk or posedge rst_cnt) begin
      if (rst_cnt) begin
         co_q <= 1'b0;
      end else begin
         co_q <= tc_c;
      end
   end

   assign co = co_q;
`else
   assign co = tc_c;
`endif

endmodule : cnt_shift_counter

// File: rtl/cnt_shift.sv
// Serial-input shift register plus an independent loadable up-counter,
// forming the datapath of a serial receiver.
// Ports:
//   clk      rising-edge clock
//   rst_sh   asynchronous active-high reset, shift register only
//   rst_cnt  asynchronous active-high reset, counter only
//   en_sh    shift enable
//   init_sh  synchronous load of SH_INIT, overrides en_sh
//   si       serial data in, enters PO_sh[0]
//   en_cnt   count enable
//   ld       synchronous load of CNT_INIT, overrides en_cnt
//   co       terminal-count flag
//   PO_sh    parallel shift-register contents
// Build option CNT_SHIFT_CO_REG_EN selects a registered co (see counter).
module cnt_shift
   import cnt_shift_pkg::*;
(
   input  logic            clk,
   input  logic            rst_sh,
   input  logic            rst_cnt,
   input  logic            en_sh,
   input  logic            init_sh,
   input  logic            si,
   input  logic            en_cnt,
   input  logic            ld,
   output logic            co,
   output logic [SH_W-1:0] PO_sh
);

   logic [CNT_W-1:0] cnt;

   // Left shift: si enters bit 0, MSB falls off
   always_ff @(posedge clk or posedge rst_sh) begin
      if (rst_sh) begin
         PO_sh <= SH_W'(0);
      end else if (init_sh) begin
         PO_sh <= SH_INIT;
      end else if (en_sh) begin
         PO_sh <= {PO_sh[SH_W-2:0], si};
      end
   end

   cnt_shift_counter u_counter (
      .clk     (clk),
      .rst_cnt (rst_cnt),
      .en_cnt  (en_cnt),
      .ld      (ld),
      .co      (co),
      .cnt     (cnt)
   );

endmodule : cnt_shift

// File: tb/tb_cnt_shift.sv
// Directed-vector bench for cnt_shift with hand-computed expectations.
module tb_cnt_shift;

`ifdef CNT_SHIFT_CO_REG_EN
   localparam bit CO_REG = 1'b1;
`else
   localparam bit CO_REG = 1'b0;
`endif

   logic       clk;
   logic       rst_sh;
   logic       rst_cnt;
   logic       en_sh;
   logic       init_sh;
   logic       si;
   logic       en_cnt;
   logic       ld;
   logic       co;
   logic [7:0] PO_sh;

   int n_vec;
   int n_err;

   cnt_shift dut (
      .clk     (clk),
      .rst_sh  (rst_sh),
      .rst_cnt (rst_cnt),
      .en_sh   (en_sh),
      .init_sh (init_sh),
      .si      (si),
      .en_cnt  (en_cnt),
      .ld      (ld),
      .co      (co),
      .PO_sh   (PO_sh)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %02h expected %02h", tag, got, exp);
      end
   endtask

   // Advance one edge and settle just after it
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [7:0] sh_bits;
   logic [7:0] sh_exp [8];

   initial begin
      n_vec   = 0;
      n_err   = 0;
      sh_bits = 8'b1001_0110;
      sh_exp  = '{8'h01, 8'h02, 8'h04, 8'h09, 8'h12, 8'h25, 8'h4B, 8'h96};

      // 1. Reset with no clock edge yet
      rst_sh = 1'b1; rst_cnt = 1'b1;
      en_sh = 1'b0; init_sh = 1'b0; si = 1'b0; en_cnt = 1'b0; ld = 1'b0;
      #3;
      chk("rst_po", PO_sh, 8'h00);
      chk("rst_co", 8'(co), 8'h00);
      chk("rst_cnt", 8'(dut.cnt), 8'h00);
      tick();
      rst_sh = 1'b0; rst_cnt = 1'b0;

      // 2. Init/load, then count through terminal count and wrap
      init_sh = 1'b1; ld = 1'b1;
      tick();
      init_sh = 1'b0; ld = 1'b0;
      chk("init_po", PO_sh, 8'h00);
      chk("ld_cnt", 8'(dut.cnt), 8'h00);
      en_cnt = 1'b1;
      for (int i = 0; i < 8; i++) begin
         #1;
         chk("run_cnt", 8'(dut.cnt), 8'(i));
         chk("run_co", 8'(co), CO_REG ? 8'h00 : 8'((i == 7) ? 1 : 0));
         tick();
      end
      en_cnt = 1'b0;
      #1;
      chk("wrap_cnt", 8'(dut.cnt), 8'h00);
      chk("wrap_co", 8'(co), CO_REG ? 8'h01 : 8'h00);
      tick();
      chk("post_co", 8'(co), 8'h00);

      // 3. Shift pattern 1,0,0,1,0,1,1,0
      en_sh = 1'b1;
      for (int i = 0; i < 8; i++) begin
         si = sh_bits[7-i];
         tick();
         chk("shift", PO_sh, sh_exp[i]);
      end
      en_sh = 1'b0;
      si    = 1'b0;
      tick();
      chk("shift_hold", PO_sh, 8'h96);

      // 4. Priority: init over shift, load over count
      init_sh = 1'b1; en_sh = 1'b1; si = 1'b1;
      tick();
      init_sh = 1'b0; en_sh = 1'b0; si = 1'b0;
      chk("init_prio", PO_sh, 8'h00);
      en_cnt = 1'b1;
      repeat (5) tick();
      chk("cnt5", 8'(dut.cnt), 8'h05);
      ld = 1'b1;
      #1;
      chk("ld_co", 8'(co), 8'h00);
      tick();
      ld = 1'b0; en_cnt = 1'b0;
      chk("ld_prio", 8'(dut.cnt), 8'h00);
      chk("ld_prio_co", 8'(co), 8'h00);

      // 5. Mid-frame resets act on their own register only
      en_sh = 1'b1; si = 1'b1; en_cnt = 1'b1;
      repeat (3) tick();
      en_cnt = 1'b0;
      tick();
      en_sh = 1'b0; si = 1'b0;
      chk("pre_rst_po", PO_sh, 8'h0F);
      chk("pre_rst_cnt", 8'(dut.cnt), 8'h03);
      #2 rst_sh = 1'b1;
      #1;
      chk("rst_sh_po", PO_sh, 8'h00);
      chk("rst_sh_cnt", 8'(dut.cnt), 8'h03);
      rst_sh = 1'b0;
      en_sh = 1'b1; si = 1'b1;
      repeat (2) tick();
      en_sh = 1'b0; si = 1'b0;
      chk("after_rst_po", PO_sh, 8'h03);
      #2 rst_cnt = 1'b1;
      #1;
      chk("rst_cnt_cnt", 8'(dut.cnt), 8'h00);
      chk("rst_cnt_po", PO_sh, 8'h03);
      rst_cnt = 1'b0;
      en_cnt = 1'b1;
      tick();
      en_cnt = 1'b0;
      chk("first_cnt", 8'(dut.cnt), 8'h01);

      // 6. Hold with both enables low
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("hold_po", PO_sh, 8'h03);
         chk("hold_cnt", 8'(dut.cnt), 8'h01);
         chk("hold_co", 8'(co), 8'h00);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_cnt_shift
